alu_op_sequencer: RTL and testbench

//  Upstream feeder for the 8-bit clocked ALU. Buffers queued operations {sel, A, B} in a FIFO
//  and issues at most one per clock onto the ALU operand/select inputs. Emits a result strobe
//  and tag aligned with the cycle in which the ALU's registered output holds that operation's

---
 rtl/alu_op_sequencer.sv | 86 ++++++++
 tb/tb_alu_op_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered issuer of {sel,A,B} ops to a clocked ALU, with a result strobe/tag aligned to ALU_Out.
// Optional ALU_SEQ_STATS_EN adds issue_count/drop_count statistics ports.
module alu_op_sequencer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_sel,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic [3:0]               alu_sel,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic                     res_valid,
  output logic [TAG_W-1:0]         res_tag,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]              issue_count,
  output logic [7:0]               drop_count,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  state_t state;
  logic [19:0] mem [DEPTH];
  logic [AW:0] wp, rp, level_next;
  logic full, empty, push, pop, iss_v;
  logic [TAG_W-1:0] tag, iss_tag;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready = !full && !flush;
  assign push = in_valid && in_ready;
  assign pop = en && !empty && !flush && state != FLUSH;
  assign fifo_count = wp - rp;
  assign level_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {in_sel, in_a, in_b};
  // iss_v/iss_tag model the ALU's one-cycle register so res_* line up with ALU_Out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      alu_sel <= '0;
      alu_a <= '0;
      alu_b <= '0;
      tag <= '0;
      iss_tag <= '0;
      iss_v <= 1'b0;
      res_valid <= 1'b0;
      res_tag <= '0;
    end else if (flush) begin
      state <= FLUSH;
      wp <= '0;
      rp <= '0;
      iss_v <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) begin
        rp <= rp + (AW+1)'(1);
        {alu_sel, alu_a, alu_b} <= mem[rp[AW-1:0]];
        iss_tag <= tag;
        tag <= tag + TAG_W'(1);
      end
      iss_v <= pop;
      res_valid <= iss_v;
      if (iss_v) res_tag <= iss_tag;
      state <= (pop && level_next != '0) ? ISSUE : IDLE;
    end
`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      issue_count <= '0;
      drop_count <= '0;
    end else begin
      if (pop && issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
      if (in_valid && full && !flush && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random stimulus checked against a queue-based reference model.
module tb_alu_op_sequencer;
  localparam int DEPTH = 8;
  logic clk = 0, rst_n = 0, en = 0, flush = 0, in_valid = 0, in_ready;
  logic [3:0] in_sel = 0, alu_sel;
  logic [7:0] in_a = 0, in_b = 0, alu_a, alu_b;
  logic res_valid;
  logic [3:0] res_tag;
  logic [3:0] fifo_count;
  logic [19:0] alu_q;
  logic [19:0] q[$];
  logic [19:0] e_alu, e_op, p_op;
  logic [3:0] m_tag, p_tag, e_rt;
  logic p_v, e_rv;
  int n_chk = 0, n_fail = 0, rv_cnt;

  alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .res_valid(res_valid), .res_tag(res_tag), .fifo_count(fifo_count));

  always #5 clk = ~clk;
  // stands in for the ALU's input register: what it sampled at each edge
  always @(posedge clk) alu_q <= {alu_sel, alu_a, alu_b};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all();
    chk("alu_ops", {alu_sel, alu_a, alu_b}, e_alu);
    chk("res_valid", res_valid, e_rv);
    if (e_rv) begin
      chk("res_tag", res_tag, e_rt);
      chk("alu_sampled", alu_q, e_op);
    end
    chk("in_ready", in_ready, q.size() < DEPTH && !flush);
    chk("fifo_count", fifo_count, q.size());
  endtask

  task automatic model_reset();
    q.delete();
    m_tag = 0; p_tag = 0; e_rt = 0;
    p_v = 0; e_rv = 0;
    e_alu = 0; e_op = 0; p_op = 0;
  endtask

  task automatic cyc(input logic v, input logic e, input logic f, input logic [19:0] op);
    int sz;
    in_valid = v; en = e; flush = f; {in_sel, in_a, in_b} = op;
    @(posedge clk);
    sz = q.size();
    if (f) begin
      q.delete();
      p_v = 0;
      e_rv = 0;
    end else begin
      e_rv = p_v;
      if (p_v) begin e_rt = p_tag; e_op = p_op; end
      if (e && sz > 0) begin
        e_alu = q.pop_front();
        p_v = 1; p_tag = m_tag; p_op = e_alu; m_tag++;
      end else p_v = 0;
      if (v && sz < DEPTH) q.push_back(op);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; en = 0; flush = 0;
    model_reset();
    #2;
    chk("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    // mid-run reset with work queued and in flight
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, $urandom);
    do_reset();
    // single op 3+4 with sel 0
    cyc(1, 1, 0, {4'h0, 8'h03, 8'h04});
    cyc(0, 1, 0, 0);
    chk("t2_sel", alu_sel, 0);
    chk("t2_a", alu_a, 8'h03);
    cyc(0, 1, 0, 0);
    chk("t2_valid", res_valid, 1);
    chk("t2_tag", res_tag, 0);
    chk("t2_sum", 8'(alu_q[15:8] + alu_q[7:0]), 8'h07);
    // fill to DEPTH, ninth push refused
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, 0, $urandom);
    chk("t3_ready", in_ready, 0);
    chk("t3_count", fifo_count, DEPTH);
    rv_cnt = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin cyc(0, 1, 0, 0); rv_cnt += res_valid; end
    chk("t3_strobes", rv_cnt, DEPTH);
    // 20 back-to-back ops across tag wrap
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, $urandom);
    for (int i = 0; i < 16; i++) begin cyc(1, 1, 0, $urandom); rv_cnt += res_valid; end
    for (int i = 0; i < 6; i++) begin cyc(0, 1, 0, 0); rv_cnt += res_valid; end
    chk("t4_strobes", rv_cnt, 20);
    // flush with one op in flight and three queued
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, $urandom);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, $urandom);
    chk("t5_valid", res_valid, 0);
    chk("t5_count", fifo_count, 0);
    cyc(0, 1, 0, 0);
    chk("t5_valid2", res_valid, 0);
    // en toggled mid-stream
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, $urandom);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("t6_count", fifo_count, 4);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    // random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(39) == 0, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
